edots_bank: RTL

Parametrised energizer-dot bank for the maze renderer. It holds N_DOTS energizers at tile positions fixed by parameter and draws each one as a procedural two-tone disc. The disc blinks on a frame-counted period. The bank consumes tile-addressed eat requests, reports each eat as a one-cycle event with the dot index, and restores the full set on level restart. It sits beside the maze and pellet layers and feeds the pixel mux with a draw request and an RGB value.

---
 rtl/edots_bank.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/edots_bank.sv
// Energizer-dot bank: tile-placed two-tone blinking discs with eat tracking and restore.
`ifndef TRNS
`define TRNS 8'hFF
`endif

module edots_bank #(
    parameter int unsigned              N_DOTS       = 4,
    parameter logic [N_DOTS-1:0][6:0]   DOT_TILE_X   = {7'd6, 7'd6, 7'd31, 7'd31},
    parameter logic [N_DOTS-1:0][6:0]   DOT_TILE_Y   = {7'd3, 7'd21, 7'd3, 7'd21},
    parameter int unsigned              BLINK_FRAMES = 15,
    parameter logic [7:0]               CORE_RGB     = 8'hC7,
    parameter logic [7:0]               RIM_RGB      = 8'hFB,
    localparam int unsigned             IW           = (N_DOTS > 1) ? $clog2(N_DOTS) : 1,
    localparam int unsigned             CW           = $clog2(N_DOTS + 1)
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [10:0]       pixel_x,
    input  logic [10:0]       pixel_y,
    input  logic              frame_start,
    input  logic              blink_en,
    input  logic              eat_valid,
    input  logic [6:0]        eat_tile_x,
    input  logic [6:0]        eat_tile_y,
    input  logic              restore,
    output logic              edots_dr,
    output logic [7:0]        edots_RGB,
    output logic [N_DOTS-1:0] alive,
    output logic              edots_exist,
    output logic [CW-1:0]     remaining,
    output logic              eaten_pulse,
    output logic [IW-1:0]     eaten_idx
);

    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [N_DOTS-1:0] r_alive;
    logic [BW-1:0]     r_cnt;
    logic              r_phase;
    logic [7:0]        r_rgb;
    logic              r_dr;
    logic              r_pulse;
    logic [IW-1:0]     r_idx;

    logic [3:0]        w_ox;
    logic [3:0]        w_oy;
    logic [3:0]        w_adx;
    logic [3:0]        w_ady;
    logic [9:0]        w_d2;
    logic [7:0]        w_shape_rgb;
    logic              w_draw_hit;
    logic              w_visible;
    logic [7:0]        w_rgb_nxt;
    logic              w_eat_hit;
    logic [IW-1:0]     w_eat_idx;
    logic [N_DOTS-1:0] w_eat_mask;
    logic [CW-1:0]     w_remaining;

    // Disc shape from in-tile offset: |2*o - 15| per axis, then squared radius.
    always_comb begin
        w_ox  = pixel_x[3:0];
        w_oy  = pixel_y[3:0];
        w_adx = w_ox[3] ? 4'({w_ox, 1'b0} - 5'd15) : 4'(5'd15 - {w_ox, 1'b0});
        w_ady = w_oy[3] ? 4'({w_oy, 1'b0} - 5'd15) : 4'(5'd15 - {w_oy, 1'b0});
        w_d2  = ({6'd0, w_adx} * {6'd0, w_adx}) + ({6'd0, w_ady} * {6'd0, w_ady});
        if (w_d2 <= 10'd100)
            w_shape_rgb = CORE_RGB;
        else if (w_d2 <= 10'd196)
            w_shape_rgb = RIM_RGB;
        else
            w_shape_rgb = `TRNS;
    end

    // Any live dot on the scanned tile draws; all dots share one shape.
    always_comb begin
        w_draw_hit = 1'b0;
        for (int i = 0; i < int'(N_DOTS); i++) begin
            if (r_alive[i] && (DOT_TILE_X[i] == pixel_x[10:4]) && (DOT_TILE_Y[i] == pixel_y[10:4]))
                w_draw_hit = 1'b1;
        end
        w_visible = !blink_en || r_phase;
        w_rgb_nxt = (w_draw_hit && w_visible) ? w_shape_rgb : `TRNS;
    end

    // Lowest-index live dot matching the eater's tile.
    always_comb begin
        w_eat_hit  = 1'b0;
        w_eat_idx  = '0;
        w_eat_mask = '0;
        for (int i = int'(N_DOTS) - 1; i >= 0; i--) begin
            if (r_alive[i] && (DOT_TILE_X[i] == eat_tile_x) && (DOT_TILE_Y[i] == eat_tile_y)) begin
                w_eat_hit  = 1'b1;
                w_eat_idx  = IW'(i);
                w_eat_mask = '0;
                w_eat_mask[i] = 1'b1;
            end
        end
    end

    // Population count of live dots.
    always_comb begin
        w_remaining = '0;
        for (int i = 0; i < int'(N_DOTS); i++)
            w_remaining = w_remaining + CW'(r_alive[i]);
    end

    // Alive flags and eat event; restore overrides any eat in the same cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_alive <= '1;
            r_pulse <= 1'b0;
            r_idx   <= '0;
        end else if (restore) begin
            r_alive <= '1;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= eat_valid && w_eat_hit;
            if (eat_valid && w_eat_hit) begin
                r_alive <= r_alive & ~w_eat_mask;
                r_idx   <= w_eat_idx;
            end
        end
    end

    // Frame-counted blink phase.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (restore) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (frame_start) begin
            if (r_cnt == BW'(BLINK_FRAMES - 1)) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + BW'(1);
            end
        end
    end

    // Registered pixel output, one cycle behind the scan position.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rgb <= `TRNS;
            r_dr  <= 1'b0;
        end else begin
            r_rgb <= w_rgb_nxt;
            r_dr  <= (w_rgb_nxt != `TRNS);
        end
    end

    assign edots_RGB   = r_rgb;
    assign edots_dr    = r_dr;
    assign alive       = r_alive;
    assign remaining   = w_remaining;
    assign edots_exist = |r_alive;
    assign eaten_pulse = r_pulse;
    assign eaten_idx   = r_idx;

endmodule
